// File: rtl/decode_issue_queue.sv
// decode_issue_queue
//   DEPTH-entry instruction/PC FIFO sitting between IF and ID/EX. The head
//   entry is decoded combinationally into a 16-bit control bundle plus
//   exception flags. The block also tracks whether the head is in a
//   branch/jump delay slot.
//
//   Optional build macro: DQ_BYPASS_EN
//     When defined, an empty queue presents the incoming instruction directly
//     on out_* in the same cycle. If out_ready is also high, that instruction
//     is consumed without ever being written into storage.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   flush             drop all entries and the delay-slot state
//   in_valid/ready    fetch-side handshake; in_instr, in_pc are the payload
//   out_valid/ready   ID/EX-side handshake; out_instr, out_pc are the head entry
//   out_ctrl          decoded control bundle:
//                     [0]regwrite [1]memtoreg [2]regdst [3]alusrc [4]branch
//                     [5]jump [6]jal [7]jr [8]bal [9]memwrite [10]memen
//                     [11]hilo_write [12]hilo_read [13]hl [14]cp0we [15]is_mfc0
//   out_ri/syscall/break/eret  exception flags; all read 0 while out_valid=0
//   out_in_delayslot  head follows a popped branch/jump
//   count             number of occupied entries
module decode_issue_queue #(
  parameter  int DEPTH = 4,
  parameter  int PC_W  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [15:0]     out_ctrl,
  output logic            out_ri,
  output logic            out_syscall,
  output logic            out_break,
  output logic            out_eret,
  output logic            out_in_delayslot,
  output logic [AW:0]     count
);

  localparam logic [15:0] C_RW  = 16'h0001, C_M2R = 16'h0002, C_RDST = 16'h0004,
                          C_ASRC = 16'h0008, C_BR = 16'h0010, C_J    = 16'h0020,
                          C_JAL = 16'h0040, C_JR  = 16'h0080, C_BAL  = 16'h0100,
                          C_MW  = 16'h0200, C_MEN = 16'h0400, C_HW   = 16'h0800,
                          C_HR  = 16'h1000, C_HL  = 16'h2000, C_CP0W = 16'h4000,
                          C_MFC0 = 16'h8000;

  logic [31:0]     instr_q [DEPTH];
  logic [PC_W-1:0] pc_q    [DEPTH];
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            ds_q, ds_d;

  logic [31:0]     head_instr;
  logic [PC_W-1:0] head_pc;
  logic            head_vld, byp, push, pop, consume;

  // Head selection: storage normally; the fetch input when bypassing.
  always_comb begin
    byp        = 1'b0;
    head_instr = instr_q[rd_q];
    head_pc    = pc_q[rd_q];
    head_vld   = (cnt_q != '0);
`ifdef DQ_BYPASS_EN
    if (cnt_q == '0 && in_valid && !flush) begin
      byp        = 1'b1;
      head_instr = in_instr;
      head_pc    = in_pc;
      head_vld   = 1'b1;
    end
`endif
  end

  assign in_ready         = (cnt_q != (AW+1)'(DEPTH));
  assign out_valid        = head_vld;
  assign out_instr        = head_instr;
  assign out_pc           = head_pc;
  assign count            = cnt_q;
  assign out_in_delayslot = ds_q & head_vld;

  // A bypassed entry that is taken immediately never touches storage.
  assign consume = head_vld & out_ready & ~flush;
  assign pop     = consume & ~byp;
  assign push    = in_valid & in_ready & ~flush & ~(byp & out_ready);

  // Head decode
  logic [5:0] op, fn;
  logic [4:0] rs, rt;
  assign op = head_instr[31:26];
  assign rs = head_instr[25:21];
  assign rt = head_instr[20:16];
  assign fn = head_instr[5:0];

  always_comb begin
    out_ctrl    = '0;
    out_ri      = 1'b0;
    out_syscall = 1'b0;
    out_break   = 1'b0;
    out_eret    = 1'b0;
    if (head_vld) begin
      case (op)
        6'h00: case (fn)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2A, 6'h2B:  out_ctrl = C_RW | C_RDST;
          6'h08:                       out_ctrl = C_J | C_JR;
          6'h09:                       out_ctrl = C_RW | C_RDST | C_J | C_JAL | C_JR;
          6'h0C:                       out_syscall = 1'b1;
          6'h0D:                       out_break   = 1'b1;
          6'h10:                       out_ctrl = C_RW | C_RDST | C_HR | C_HL;
          6'h12:                       out_ctrl = C_RW | C_RDST | C_HR;
          6'h11:                       out_ctrl = C_HW | C_HL;
          6'h13:                       out_ctrl = C_HW;
          6'h18, 6'h19, 6'h1A, 6'h1B:  out_ctrl = '0;   // mult/div: no GPR write
          default:                     out_ri = 1'b1;
        endcase
        6'h01: case (rt)
          5'h00, 5'h01:                out_ctrl = C_BR;
          5'h10, 5'h11:                out_ctrl = C_RW | C_BR | C_BAL;
          default:                     out_ri = 1'b1;
        endcase
        6'h02:                         out_ctrl = C_J;
        6'h03:                         out_ctrl = C_RW | C_J | C_JAL;
        6'h04, 6'h05, 6'h06, 6'h07:    out_ctrl = C_BR;
        6'h08, 6'h09, 6'h0A, 6'h0B,
        6'h0C, 6'h0D, 6'h0E, 6'h0F:    out_ctrl = C_RW | C_ASRC;
        6'h10: begin
          // ERET is matched on the full word; any other COP0 encoding is decoded by rs.
          if (head_instr == 32'h4200_0018) out_eret = 1'b1;
          else case (rs)
            5'h00:   out_ctrl = C_RW | C_MFC0;
            5'h04:   out_ctrl = C_CP0W;
            default: out_ri = 1'b1;
          endcase
        end
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25: out_ctrl = C_RW | C_M2R | C_ASRC | C_MEN;
        6'h28, 6'h29, 6'h2B:           out_ctrl = C_ASRC | C_MW | C_MEN;
        default:                       out_ri = 1'b1;
      endcase
    end
  end

  // Next state; flush wins over push and pop.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    ds_d  = ds_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      ds_d  = 1'b0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
      // Delay slot follows whatever was just consumed; it holds across empty periods.
      if (consume) ds_d = out_ctrl[4] | out_ctrl[5];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ds_q  <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ds_q  <= ds_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_q] <= in_instr;
      pc_q[wr_q]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Testbench for decode_issue_queue: directed steps followed by a randomized
// run. The queue model is a SystemVerilog queue. The decoder model
// classifies each word by mnemonic into the control values listed for it.
module tb_decode_issue_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] in_instr = '0, out_instr;
  logic [PC_W-1:0] in_pc = '0, out_pc;
  logic [15:0] out_ctrl;
  logic out_ri, out_syscall, out_break, out_eret, out_in_delayslot;
  logic [AW:0] count;

  int vectors = 0, miscompares = 0;

  decode_issue_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_ctrl(out_ctrl), .out_ri(out_ri), .out_syscall(out_syscall), .out_break(out_break),
    .out_eret(out_eret), .out_in_delayslot(out_in_delayslot), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] i; logic [PC_W-1:0] p; } ent_t;
  ent_t mq[$];
  bit   mds = 0;

  // Returns {eret, break, syscall, ri, ctrl[15:0]}.
  function automatic logic [19:0] ref_dec(input logic [31:0] w);
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    logic [15:0] c;
    bit ri, sc, bk, er;
    op = w[31:26]; fn = w[5:0]; rs = w[25:21]; rt = w[20:16];
    c = 16'h0; ri = 0; sc = 0; bk = 0; er = 0;
    if (w == 32'h42000018) er = 1;
    else if (op == 6'h00) begin
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B})
        c = 16'h0005;
      else if (fn == 6'h10) c = 16'h3005;             // MFHI
      else if (fn == 6'h12) c = 16'h1005;             // MFLO
      else if (fn == 6'h11) c = 16'h2800;             // MTHI
      else if (fn == 6'h13) c = 16'h0800;             // MTLO
      else if (fn inside {[6'h18:6'h1B]}) c = 16'h0;  // MULT/DIV family
      else if (fn == 6'h08) c = 16'h00A0;             // JR
      else if (fn == 6'h09) c = 16'h00E5;             // JALR
      else if (fn == 6'h0C) sc = 1;
      else if (fn == 6'h0D) bk = 1;
      else ri = 1;
    end else if (op == 6'h01) begin
      if (rt inside {5'h00, 5'h01}) c = 16'h0010;
      else if (rt inside {5'h10, 5'h11}) c = 16'h0111;
      else ri = 1;
    end
    else if (op == 6'h02) c = 16'h0020;
    else if (op == 6'h03) c = 16'h0061;
    else if (op inside {[6'h04:6'h07]}) c = 16'h0010;
    else if (op inside {[6'h08:6'h0F]}) c = 16'h0009;
    else if (op == 6'h10) begin
      if (rs == 5'h00) c = 16'h8001;
      else if (rs == 5'h04) c = 16'h4000;
      else ri = 1;
    end
    else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) c = 16'h040B;
    else if (op inside {6'h28, 6'h29, 6'h2B}) c = 16'h0608;
    else ri = 1;
    return {er, bk, sc, ri, c};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive, check against model before the edge, then advance the model.
  task automatic step(input bit iv, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                      input bit ordy, input bit fl);
    bit ev, byp;
    ent_t h;
    logic [19:0] d;
    int n;
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    byp = 0;
`ifdef DQ_BYPASS_EN
    if (mq.size() == 0 && iv && !fl) byp = 1;
`endif
    ev = (mq.size() != 0) || byp;
    h = '0;
    if (byp) begin h.i = ins; h.p = pc; end
    else if (mq.size() != 0) h = mq[0];
    d = ev ? ref_dec(h.i) : 20'h0;
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    chk("count", 64'(count), 64'(mq.size()));
    if (ev) begin
      chk("out_instr", 64'(out_instr), 64'(h.i));
      chk("out_pc", 64'(out_pc), 64'(h.p));
    end
    chk("out_ctrl", 64'(out_ctrl), 64'(d[15:0]));
    chk("flags", 64'({out_eret, out_break, out_syscall, out_ri}), 64'(d[19:16]));
    chk("delayslot", 64'(out_in_delayslot), 64'(mds & ev));
    n = mq.size();
    @(posedge clk);
    if (fl) begin
      mq.delete();
      mds = 0;
    end else begin
      if (ev && ordy) begin
        mds = d[4] | d[5];
        if (!byp) void'(mq.pop_front());
      end
      if (iv && n < DEPTH && !(byp && ordy)) begin
        h.i = ins; h.p = pc;
        mq.push_back(h);
      end
    end
    #1;
    in_valid = 0; out_ready = 0; flush = 0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    int k;
    logic [5:0] mem_ops[8];
    logic [4:0] rts[5];
    mem_ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    rts = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h05};
    w = $urandom;
    k = $urandom_range(0, 7);
    case (k)
      0, 1: w[31:26] = 6'h00;
      2: begin w[31:26] = 6'h01; w[20:16] = rts[$urandom_range(0, 4)]; end
      3: w[31:26] = 6'($urandom_range(2, 15));
      4: begin w[31:26] = 6'h10; w[25:21] = ($urandom_range(0, 2) == 0) ? 5'h00 :
                                             ($urandom_range(0, 1) == 0) ? 5'h04 : 5'h10; end
      5: w[31:26] = mem_ops[$urandom_range(0, 7)];
      6: w = 32'h42000018;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_flags", 64'({out_eret, out_break, out_syscall, out_ri, out_in_delayslot}), 64'd0);
    rst = 0;
    @(negedge clk);

    // LUI appears one edge after push
    step(1, 32'h3C011234, 32'hBFC00000, 0, 0);
    chk("lui_valid", 64'(out_valid), 64'd1);
    chk("lui_ctrl", 64'(out_ctrl), 64'h0009);
    chk("lui_count", 64'(count), 64'd1);
    chk("lui_pc", 64'(out_pc), 64'hBFC00000);
    step(0, 0, 0, 1, 0);

    // Fill past full, then drain in order
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h24000000 + 32'(i), 32'(32'h100 + 4 * i), 0, 0);
      if (i == 3) chk("full_in_ready", 64'(in_ready), 64'd0);
    end
    chk("full_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 64'(out_instr), 64'(32'h24000000 + 32'(i)));
      step(0, 0, 0, 1, 0);
    end
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Delay slot after BEQ
    step(1, 32'h10220003, 32'h200, 0, 0);
    step(1, 32'h00221821, 32'h204, 1, 0);
    chk("ds_addu", 64'(out_in_delayslot), 64'd1);
    step(1, 32'h34210001, 32'h208, 1, 0);
    chk("ds_third", 64'(out_in_delayslot), 64'd0);
    step(0, 0, 0, 1, 0);

    // Reserved instruction and ERET
    step(1, 32'h0000003F, 32'h300, 0, 0);
    chk("ri_flag", 64'(out_ri), 64'd1);
    chk("ri_ctrl", 64'(out_ctrl), 64'd0);
    step(1, 32'h42000018, 32'h304, 1, 0);
    chk("eret_flag", 64'(out_eret), 64'd1);
    chk("eret_ri", 64'(out_ri), 64'd0);
    step(0, 0, 0, 1, 0);

    // Flush with push and pop in the same cycle; delay-slot state armed first
    step(1, 32'h10220003, 32'h400, 0, 0);
    step(1, 32'h00221821, 32'h404, 1, 0);
    step(1, 32'h00221821, 32'h408, 0, 0);
    step(1, 32'h00221821, 32'h40C, 0, 0);
    chk("pre_flush_count", 64'(count), 64'd3);
    chk("pre_flush_ds", 64'(out_in_delayslot), 64'd1);
    step(1, 32'h00221821, 32'h410, 1, 1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    step(1, 32'h00221821, 32'h414, 0, 0);
    chk("flush_ds", 64'(out_in_delayslot), 64'd0);
    step(0, 0, 0, 1, 0);

`ifdef DQ_BYPASS_EN
    // Bypass on an empty queue
    in_valid = 1; in_instr = 32'h0C000010; in_pc = 32'h500; out_ready = 1;
    #1;
    chk("byp_valid", 64'(out_valid), 64'd1);
    chk("byp_ctrl", 64'(out_ctrl), 64'h0061);
    step(1, 32'h0C000010, 32'h500, 1, 0);
    chk("byp_count", 64'(count), 64'd0);
`endif

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 9) < 6, rnd_instr(), $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
